// File: rtl/l2_cache_ctrl_wb_if.sv
// Bundle between the L2 control FSM, the L2 datapath arrays and the pmem arbiter.
// master = datapath/CPU/pmem side, slave = l2_cache_ctrl_wb.
interface l2_cache_ctrl_wb_if #(
  parameter int NUM_WAYS   = 8,
  parameter int WAYS_LOG_2 = $clog2(NUM_WAYS)
);
  logic                                 mem_read;
  logic                                 mem_write;
  logic                                 mem_resp;
  logic                                 pmem_resp;
  logic                                 pmem_read;
  logic                                 pmem_write;
  logic                                 hit;
  logic [WAYS_LOG_2-1:0]                hit_way;
  logic [NUM_WAYS-1:0]                  valid_out;
  logic [NUM_WAYS-1:0]                  dirty_out;
  logic [NUM_WAYS-1:0][WAYS_LOG_2-1:0]  lru_out;
  logic [WAYS_LOG_2-1:0]                way_sel;
  logic                                 tag_load;
  logic                                 valid_load;
  logic                                 dirty_load;
  logic                                 dirty_in;
  logic [1:0]                           writing;
  logic                                 addr_sel;
  logic [NUM_WAYS-1:0]                  lru_load;
  logic [NUM_WAYS-1:0][WAYS_LOG_2-1:0]  lru_in;
  logic [31:0]                          hit_cnt;
  logic [31:0]                          miss_cnt;
  logic [31:0]                          wb_cnt;

  modport master (
    output mem_read, mem_write, pmem_resp, hit, hit_way, valid_out, dirty_out, lru_out,
    input  mem_resp, pmem_read, pmem_write, way_sel, tag_load, valid_load, dirty_load,
           dirty_in, writing, addr_sel, lru_load, lru_in, hit_cnt, miss_cnt, wb_cnt
  );

  modport slave (
    input  mem_read, mem_write, pmem_resp, hit, hit_way, valid_out, dirty_out, lru_out,
    output mem_resp, pmem_read, pmem_write, way_sel, tag_load, valid_load, dirty_load,
           dirty_in, writing, addr_sel, lru_load, lru_in, hit_cnt, miss_cnt, wb_cnt
  );
endinterface

// File: rtl/l2_cache_ctrl_wb.sv
// N-way write-back/write-allocate L2 control FSM with registered victim selection and LRU ageing.
// Optional perf counters enabled by defining L2_PERF_CNT_EN.
module l2_cache_ctrl_wb #(
  parameter int NUM_WAYS   = 8,
  parameter int WAYS_LOG_2 = $clog2(NUM_WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  l2_cache_ctrl_wb_if.slave bus
);
  // state | meaning
  // CHECK | tag lookup; hit completes here, miss latches victim
  // WB    | dirty victim line written to pmem
  // FILL  | new line read from pmem into victim way
  typedef enum logic [1:0] {
    CHECK = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2
  } state_e;

  localparam logic [WAYS_LOG_2-1:0] AGE_MAX = WAYS_LOG_2'(NUM_WAYS - 1);

  state_e                state_q, state_d;
  logic [WAYS_LOG_2-1:0] victim_q, victim_d;
  logic [WAYS_LOG_2-1:0] victim_pick;
  logic [WAYS_LOG_2-1:0] touch_way;
  logic [WAYS_LOG_2-1:0] touch_age;
  logic                  req;
  logic                  victim_dirty;
  logic                  touch_en;
  logic                  hit_evt;
  logic                  miss_evt;
  logic                  wb_evt;

  assign req = bus.mem_read | bus.mem_write;

  // Descending scans so the lowest index wins; invalid ways override the LRU pick.
  always_comb begin : victim_select
    victim_pick = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (bus.lru_out[i] == AGE_MAX) victim_pick = WAYS_LOG_2'(i);
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!bus.valid_out[i]) victim_pick = WAYS_LOG_2'(i);
    end
  end

  assign victim_dirty = bus.valid_out[victim_pick] & bus.dirty_out[victim_pick];

  always_comb begin : fsm_comb
    state_d         = state_q;
    victim_d        = victim_q;
    bus.mem_resp    = 1'b0;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.way_sel     = victim_q;
    bus.tag_load    = 1'b0;
    bus.valid_load  = 1'b0;
    bus.dirty_load  = 1'b0;
    bus.dirty_in    = 1'b0;
    bus.writing     = 2'b11;
    bus.addr_sel    = 1'b0;
    touch_en        = 1'b0;
    touch_way       = victim_q;
    hit_evt         = 1'b0;
    miss_evt        = 1'b0;
    wb_evt          = 1'b0;
    // Outputs are held at defaults while reset is asserted.
    if (rst_n) begin
      case (state_q)
        CHECK: begin
          if (req) begin
            if (bus.hit) begin
              bus.mem_resp = 1'b1;
              bus.way_sel  = bus.hit_way;
              touch_en     = 1'b1;
              touch_way    = bus.hit_way;
              hit_evt      = 1'b1;
              if (bus.mem_write) begin
                bus.dirty_load = 1'b1;
                bus.dirty_in   = 1'b1;
                bus.writing    = 2'b01;
              end
            end else begin
              victim_d = victim_pick;
              miss_evt = 1'b1;
              state_d  = victim_dirty ? WB : FILL;
            end
          end
        end
        WB: begin
          bus.pmem_write = 1'b1;
          bus.addr_sel   = 1'b1;
          if (bus.pmem_resp) begin
            wb_evt  = 1'b1;
            state_d = FILL;
          end
        end
        FILL: begin
          bus.pmem_read = 1'b1;
          bus.writing   = 2'b00;
          if (bus.pmem_resp) begin
            bus.tag_load   = 1'b1;
            bus.valid_load = 1'b1;
            bus.dirty_load = 1'b1;
            touch_en       = 1'b1;
            state_d        = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

  // An invalid touched way counts as oldest, so every valid way ages by one.
  always_comb begin : lru_update
    bus.lru_load = '0;
    bus.lru_in   = '0;
    touch_age    = bus.valid_out[touch_way] ? bus.lru_out[touch_way] : AGE_MAX;
    if (touch_en) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (WAYS_LOG_2'(i) == touch_way) begin
          bus.lru_load[i] = 1'b1;
          bus.lru_in[i]   = '0;
        end else if (bus.valid_out[i] && (bus.lru_out[i] < touch_age)) begin
          bus.lru_load[i] = 1'b1;
          bus.lru_in[i]   = bus.lru_out[i] + WAYS_LOG_2'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CHECK;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin : perf_comb
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit_evt && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_evt && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    if (wb_evt && (wb_cnt_q != '1))     wb_cnt_d   = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
  assign bus.wb_cnt   = wb_cnt_q;
`else
  logic unused_evt;
  assign unused_evt   = hit_evt ^ miss_evt ^ wb_evt;
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
  assign bus.wb_cnt   = '0;
`endif

endmodule
